// File: rtl/fp_multiplier_if.sv
// Operand/result bundle for the floating-point multiplier.
// master drives the operands, slave (the multiplier) returns the product.
interface fp_multiplier_if #(
  parameter int NB_TOTAL = 10
);
  logic                i_valid;
  logic [NB_TOTAL-1:0] A;
  logic [NB_TOTAL-1:0] B;
  logic                o_valid;
  logic [NB_TOTAL-1:0] C;

  modport master (output i_valid, A, B, input  o_valid, C);
  modport slave  (input  i_valid, A, B, output o_valid, C);
endinterface

// File: rtl/fp_multiplier.sv
// Custom-format FP multiplier: combinational product, truncating normalisation,
// zero/underflow flush and overflow saturation, then one output register.
module fp_multiplier #(
  parameter int NB_EXP   = 4,
  parameter int NB_MANT  = 5,
  parameter int NB_TOTAL = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_multiplier_if.slave bus
);
  localparam int BIAS_I = (1 << (NB_EXP - 1)) - 1;
  localparam int EMAX_I = (1 << NB_EXP) - 1;
  localparam logic signed [NB_EXP+1:0] BIAS = BIAS_I[NB_EXP+1:0];
  localparam logic signed [NB_EXP+1:0] EMAX = EMAX_I[NB_EXP+1:0];

  logic                      sign;
  logic [NB_EXP-1:0]         ea, eb;
  logic [NB_MANT:0]          ma, mb;
  logic [2*NB_MANT+1:0]      prod;
  logic                      norm;
  logic                      zero_in;
  logic [NB_MANT-1:0]        frac;
  logic signed [NB_EXP+1:0]  e_res;
  logic [NB_TOTAL-1:0]       result;
  logic                      valid_q;
  logic [NB_TOTAL-1:0]       c_q;

  assign sign    = bus.A[NB_TOTAL-1] ^ bus.B[NB_TOTAL-1];
  assign ea      = bus.A[NB_TOTAL-2:NB_MANT];
  assign eb      = bus.B[NB_TOTAL-2:NB_MANT];
  assign ma      = {1'b1, bus.A[NB_MANT-1:0]};
  assign mb      = {1'b1, bus.B[NB_MANT-1:0]};
  assign prod    = ma * mb;
  assign norm    = prod[2*NB_MANT+1];
  assign zero_in = (ea == '0) || (eb == '0);
  assign frac    = norm ? prod[2*NB_MANT:NB_MANT+1] : prod[2*NB_MANT-1:NB_MANT];

  // Two extra bits keep the biased sum from wrapping in either direction.
  assign e_res = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS
               + $signed({{(NB_EXP+1){1'b0}}, norm});

  always_comb begin
    result = {sign, e_res[NB_EXP-1:0], frac};
    if (zero_in || e_res <= 0)
      result = {sign, {(NB_TOTAL-1){1'b0}}};
    else if (e_res >= EMAX)
      result = {sign, {(NB_TOTAL-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      c_q     <= '0;
    end else begin
      valid_q <= bus.i_valid;
      if (bus.i_valid) c_q <= result;
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.C       = c_q;
endmodule

// File: tb/tb_fp_multiplier.sv
// Bench for fp_multiplier: fixed vector table, random vectors against a real-valued
// model, valid-pipeline sequences and asynchronous reset, all through a result queue.
module tb_fp_multiplier;
  localparam int NB_EXP   = 4;
  localparam int NB_MANT  = 5;
  localparam int NB_TOTAL = 10;
  typedef logic [NB_TOTAL-1:0] word_t;

  typedef struct {
    word_t a;
    word_t b;
    word_t c;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  word_t exp_q[$];

  fp_multiplier_if #(.NB_TOTAL(NB_TOTAL)) bus ();

  fp_multiplier #(.NB_EXP(NB_EXP), .NB_MANT(NB_MANT), .NB_TOTAL(NB_TOTAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Independent reference: evaluate with reals, renormalise, truncate.
  function automatic word_t model(input word_t a, input word_t b);
    logic s;
    int   ea, eb, k, e, f;
    real  m;
    word_t r;
    s  = a[NB_TOTAL-1] ^ b[NB_TOTAL-1];
    ea = int'(a[NB_TOTAL-2:NB_MANT]);
    eb = int'(b[NB_TOTAL-2:NB_MANT]);
    if (ea == 0 || eb == 0) return {s, 9'd0};
    m = (1.0 + real'(a[NB_MANT-1:0]) / 32.0) * (1.0 + real'(b[NB_MANT-1:0]) / 32.0);
    k = ea + eb - 14;
    if (m >= 2.0) begin
      m = m / 2.0;
      k++;
    end
    e = k + 7;
    if (e <= 0) return {s, 9'd0};
    if (e >= 15) return {s, 9'h1ff};
    f = int'($floor((m - 1.0) * 32.0));
    r = {s, e[3:0], f[4:0]};
    return r;
  endfunction

  task automatic drive(input logic v, input word_t a, input word_t b, input word_t e);
    @(posedge clk);
    #1;
    bus.i_valid = v;
    bus.A       = a;
    bus.B       = b;
    if (v) exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Scoreboard: every cycle with o_valid high must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %b with no pending expectation", bus.C);
      end else begin
        chk("result", bus.C, exp_q.pop_front());
      end
    end
  end

  initial begin
    vec_t  tbl[16];
    word_t a, b, e;

    tbl[0]  = '{10'b0_1001_01000, 10'b0_1010_01000, 10'b0_1100_10010};
    tbl[1]  = '{10'b0_0110_00000, 10'b0_1010_01000, 10'b0_1001_01000};
    tbl[2]  = '{10'b0_1000_01100, 10'b1_1000_10110, 10'b1_1010_00101};
    tbl[3]  = '{10'b0_0000_00000, 10'b1_1010_01000, 10'b1_0000_00000};
    tbl[4]  = '{10'b0_1110_11111, 10'b0_1110_11111, 10'b0_1111_11111};
    tbl[5]  = '{10'b0_0010_00000, 10'b0_0010_00000, 10'b0_0000_00000};
    tbl[6]  = '{10'b0_1011_00000, 10'b0_1011_00000, 10'b0_1111_11111};
    tbl[7]  = '{10'b0_1011_00000, 10'b0_1010_00000, 10'b0_1110_00000};
    tbl[8]  = '{10'b0_0011_00000, 10'b0_0100_00000, 10'b0_0000_00000};
    tbl[9]  = '{10'b0_0100_00000, 10'b0_0100_00000, 10'b0_0001_00000};
    tbl[10] = '{10'b0_1010_11111, 10'b0_1011_11111, 10'b0_1111_11111};
    tbl[11] = '{10'b0_1111_00000, 10'b0_0001_00000, 10'b0_1001_00000};
    tbl[12] = '{10'b1_1010_01000, 10'b1_0000_00111, 10'b0_0000_00000};
    tbl[13] = '{10'b1_0111_00000, 10'b0_0111_00000, 10'b1_0111_00000};
    tbl[14] = '{10'b0_0011_11111, 10'b0_0011_11111, 10'b0_0000_00000};
    tbl[15] = '{10'b0_0011_11111, 10'b0_0100_11111, 10'b0_0001_11110};

    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.A       = '0;
    bus.B       = '0;
    #1;
    chk("reset_c", bus.C, '0);
    chk("reset_valid", word_t'(bus.o_valid), '0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].c);
    drive(1'b0, '0, '0, '0);
    drain();

    for (int i = 0; i < 40; i++) begin
      a = word_t'($urandom_range(0, 1023));
      b = word_t'($urandom_range(0, 1023));
      drive(1'b1, a, b, model(a, b));
      if ($urandom_range(0, 3) == 0) drive(1'b0, '0, '0, '0);
    end
    drive(1'b0, '0, '0, '0);
    drain();

    // Single pulse: one valid cycle, then C holds with o_valid low.
    drive(1'b1, tbl[0].a, tbl[0].b, tbl[0].c);
    drive(1'b0, 10'h3ff, 10'h3ff, '0);
    chk("pulse_valid_hi", word_t'(bus.o_valid), 1);
    chk("pulse_c", bus.C, tbl[0].c);
    @(posedge clk); #1;
    chk("pulse_valid_lo", word_t'(bus.o_valid), 0);
    chk("pulse_hold1", bus.C, tbl[0].c);
    @(posedge clk); #1;
    chk("pulse_hold2", bus.C, tbl[0].c);

    // Back-to-back stream: results on consecutive cycles.
    drive(1'b1, tbl[0].a, tbl[0].b, tbl[0].c);
    drive(1'b1, tbl[1].a, tbl[1].b, tbl[1].c);
    chk("stream_v1", word_t'(bus.o_valid), 1);
    drive(1'b1, tbl[2].a, tbl[2].b, tbl[2].c);
    chk("stream_v2", word_t'(bus.o_valid), 1);
    drive(1'b0, '0, '0, '0);
    chk("stream_v3", word_t'(bus.o_valid), 1);
    chk("stream_c3", bus.C, tbl[2].c);
    @(posedge clk); #1;
    chk("stream_end", word_t'(bus.o_valid), 0);
    chk("stream_hold", bus.C, tbl[2].c);
    drain();

    // Asynchronous reset while a result is on the output.
    drive(1'b1, tbl[0].a, tbl[0].b, tbl[0].c);
    drive(1'b0, '0, '0, '0);
    #6;
    rst_n = 1'b0;
    #1;
    chk("async_rst_c", bus.C, '0);
    chk("async_rst_valid", word_t'(bus.o_valid), 0);
    bus.i_valid = 1'b1;
    bus.A       = tbl[0].a;
    bus.B       = tbl[0].b;
    @(posedge clk); #1;
    chk("rst_held_c", bus.C, '0);
    chk("rst_held_valid", word_t'(bus.o_valid), 0);
    bus.i_valid = 1'b0;
    #2 rst_n = 1'b1;
    drive(1'b1, tbl[1].a, tbl[1].b, tbl[1].c);
    drive(1'b0, '0, '0, '0);
    chk("post_rst_c", bus.C, tbl[1].c);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
